// File: rtl/chan_mux_rr.sv
// Channel multiplexer with fixed-select and round-robin modes feeding a one-word output register.
// Optional build macro CHAN_MUX_PARITY_EN adds a registered out_parity output (XOR of the word).
module chan_mux_rr #(
   parameter  int unsigned WIDTH    = 8,
   parameter  int unsigned CHANNELS = 4,
   localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
`ifdef CHAN_MUX_PARITY_EN
   output logic                      out_parity,
`endif
   input  logic                      out_ready
);

   localparam int unsigned SEL_SPAN = 2 ** SEL_W;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]          r_state;
   logic [0:0]          w_next_state;
   logic [SEL_W-1:0]    r_rr_ptr;
   logic [WIDTH-1:0]    r_out_data;
   logic [SEL_W-1:0]    r_out_chan;

   logic [SEL_SPAN-1:0] w_valid_pad;
   logic [SEL_W-1:0]    w_cand;
   logic                w_load;
   logic                w_grant;
   logic [SEL_W-1:0]    w_idx;
   logic [CHANNELS-1:0] w_ready;
   logic [WIDTH-1:0]    w_data;

   // Grant decision: padding makes out-of-range fixed selects see an idle channel.
   always_comb begin
      w_valid_pad                 = '0;
      w_valid_pad[CHANNELS-1:0]   = in_valid;
      w_load                      = (r_state == ST_EMPTY) || out_ready;
      w_grant                     = 1'b0;
      w_idx                       = '0;
      w_cand                      = '0;
      if (w_load && !rst) begin
         if (!mode) begin
            w_grant = w_valid_pad[sel];
            w_idx   = sel;
         end else begin
            // Walk downward so the nearest channel after rr_ptr wins last.
            for (int k = CHANNELS; k >= 1; k--) begin
               w_cand = SEL_W'((int'(r_rr_ptr) + k) % int'(CHANNELS));
               if (w_valid_pad[w_cand]) begin
                  w_grant = 1'b1;
                  w_idx   = w_cand;
               end
            end
         end
      end
   end

   // One-hot accept strobe and the granted channel's data.
   always_comb begin
      w_ready = '0;
      w_data  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_ready[i] = w_grant && (w_idx == SEL_W'(i));
         if (w_idx == SEL_W'(i)) begin
            w_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (w_load) begin
         w_next_state = w_grant ? ST_FULL : ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Output word and round-robin pointer only move on a grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data <= '0;
         r_out_chan <= '0;
         r_rr_ptr   <= SEL_W'(CHANNELS - 1);
      end else if (w_grant) begin
         r_out_data <= w_data;
         r_out_chan <= w_idx;
         if (mode) begin
            r_rr_ptr <= w_idx;
         end
      end
   end

`ifdef CHAN_MUX_PARITY_EN
   logic r_out_parity;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_parity <= 1'b0;
      end else if (w_grant) begin
         r_out_parity <= ^w_data;
      end
   end

   assign out_parity = r_out_parity;
`endif

   assign in_ready  = w_ready;
   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;
   assign out_valid = (r_state == ST_FULL);

endmodule

// File: tb/tb_chan_mux_rr.sv
// Scoreboard bench for chan_mux_rr (WIDTH=8, CHANNELS=4): directed cases plus random traffic.
module tb_chan_mux_rr;

   localparam int CH = 4;
   localparam int W  = 8;

   typedef struct packed {
      logic [W-1:0] d;
      logic [1:0]   c;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH*W-1:0] in_data;
   logic [CH-1:0] in_valid;
   logic [CH-1:0] in_ready;
   logic          mode;
   logic [1:0]    sel;
   logic [W-1:0]  out_data;
   logic [1:0]    out_chan;
   logic          out_valid;
   logic          out_ready;
`ifdef CHAN_MUX_PARITY_EN
   logic          out_parity;
`endif

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   // Reference model state: is a word held, and which channel was granted last in RR mode.
   logic m_full;
   int   m_ptr;
   logic last_g;
   int   last_idx;

   chan_mux_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
`ifdef CHAN_MUX_PARITY_EN
      .out_parity(out_parity),
`endif
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_full = 1'b0;
      m_ptr  = CH - 1;
   endtask

   // Decide the grant for this cycle from the rules, check in_ready, queue the expected word.
   task automatic model_step();
      logic          load;
      logic          g;
      int            idx;
      logic [CH-1:0] exp_rdy;
      exp_t          e;
      load = !m_full || out_ready;
      g    = 1'b0;
      idx  = 0;
      if (load) begin
         if (!mode) begin
            if (int'(sel) < CH && in_valid[sel]) begin
               g   = 1'b1;
               idx = int'(sel);
            end
         end else begin
            for (int k = 1; k <= CH; k++) begin
               int c;
               c = (m_ptr + k) % CH;
               if (!g && in_valid[c]) begin
                  g   = 1'b1;
                  idx = c;
               end
            end
         end
      end
      exp_rdy = g ? CH'(1 << idx) : '0;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (g) begin
         e.d = in_data[idx*W +: W];
         e.c = 2'(idx);
         q.push_back(e);
         if (mode) m_ptr = idx;
         m_full = 1'b1;
      end else if (load) begin
         m_full = 1'b0;
      end
      last_g   = g;
      last_idx = idx;
   endtask

   task automatic drive(input logic [CH-1:0] v, input logic [CH*W-1:0] d,
                        input logic m, input logic [1:0] s, input logic r);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      mode      = m;
      sel       = s;
      out_ready = r;
      #2;
      model_step();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Monitor: pops and compares whenever the DUT hands a word downstream.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (out_valid && out_ready && q.size() != 0) begin
               e = q.pop_front();
               check("out_data", 32'(out_data), 32'(e.d));
               check("out_chan", 32'(out_chan), 32'(e.c));
`ifdef CHAN_MUX_PARITY_EN
               check("out_parity", 32'(out_parity), 32'(^e.d));
`endif
            end
         end
      end
   end

   initial begin
      logic [CH*W-1:0] dd;
      int rr_exp[6];
      rr_exp = '{0, 1, 3, 0, 1, 3};

      rst = 1'b1; in_valid = '0; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
      model_reset();
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_chan", 32'(out_chan), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Fixed select of channel 2 while all channels request.
      drive(4'b1111, 32'h11A5_2233, 1'b0, 2'd2, 1'b1);
      check("fixed_in_ready", 32'(in_ready), 32'h4);
      drive(4'b0000, 32'h0, 1'b0, 2'd2, 1'b1);
      check("fixed_out_data", 32'(out_data), 32'hA5);
      check("fixed_out_chan", 32'(out_chan), 32'd2);

      // Round-robin order with channel 2 idle.
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         drive(4'b1011, {8'(40 + i), 8'(30 + i), 8'(20 + i), 8'(10 + i)}, 1'b1, 2'd0, 1'b1);
         check("rr_order", 32'(in_ready), 32'(1 << rr_exp[i]));
      end

      // Backpressure: word 3C must hold for five cycles.
      drive(4'b0010, 32'h0000_3C00, 1'b0, 2'd1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(4'b1111, 32'hFFFF_FFFF, 1'b1, 2'd1, 1'b0);
         check("bp_in_ready", 32'(in_ready), 32'h0);
         check("bp_hold_data", 32'(out_data), 32'h3C);
      end
      drive(4'b0000, 32'h0, 1'b0, 2'd0, 1'b1);

      // Boundary: fixed select of an idle channel, then RR wrap onto channel 3.
      pulse_reset();
      drive(4'b1011, 32'h7777_7777, 1'b0, 2'd2, 1'b1);
      check("idle_sel_no_grant", 32'(in_ready), 32'h0);
      drive(4'b1000, 32'h9900_0000, 1'b1, 2'd0, 1'b1);
      check("rr_wrap_ch3", 32'(in_ready), 32'h8);

`ifdef CHAN_MUX_PARITY_EN
      drive(4'b0001, 32'h0000_00B1, 1'b0, 2'd0, 1'b1);
      drive(4'b0001, 32'h0000_0080, 1'b0, 2'd0, 1'b1);
      check("parity_b1", 32'(out_parity), 32'd0);
      drive(4'b0000, 32'h0, 1'b0, 2'd0, 1'b1);
      check("parity_80", 32'(out_parity), 32'd1);
`endif

      // Reset while holding a word must clear outputs without a clock edge.
      drive(4'b0001, 32'h0000_0055, 1'b0, 2'd0, 1'b1);
      drive(4'b0000, 32'h0, 1'b0, 2'd0, 1'b0);
      in_valid = 4'b1111; mode = 1'b1; out_ready = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check("midrst_out_chan", 32'(out_chan), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      drive(4'b0100, 32'h00C3_0000, 1'b1, 2'd0, 1'b1);
      check("first_grant_after_rst", 32'(in_ready), 32'h4);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         dd = {$urandom(), $urandom()} >> 32;
         drive(4'($urandom_range(0, 15)), dd, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
      end

      for (int i = 0; i < 4 && q.size() != 0; i++) begin
         drive(4'b0000, 32'h0, 1'b0, 2'd0, 1'b1);
      end
      @(negedge clk);
      #3;
      check("drain_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chan_mux_rr.md
CHAN_MUX_RR -- requirements
Module: chan_mux_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (1..32).
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 SHALL derive localparam SEL_W = clog2(CHANNELS), minimum 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port in_data, input, CHANNELS*WIDTH, packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid, input, CHANNELS, per-channel data-valid.
REQ-008 SHALL have port in_ready, output, CHANNELS, per-channel accept strobe, at most one bit high.
REQ-009 SHALL have port mode, input, 1, selection mode: 0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port sel, input, SEL_W, channel index used in fixed mode.
REQ-011 SHALL have port out_data, output, WIDTH, registered selected data.
REQ-012 SHALL have port out_chan, output, SEL_W, index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid, output, 1, out_data/out_chan hold a word.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts the word when high with out_valid.

Function
REQ-015 SHALL implement two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL define load = !out_valid | out_ready; a grant is made only when load=1.
REQ-017 Fixed mode: SHALL grant channel sel when load=1 and in_valid[sel]=1; in_valid on other channels ignored.
REQ-018 Fixed mode: sel >= CHANNELS SHALL produce no grant and no state change.
REQ-019 Round-robin mode: SHALL grant the first channel with in_valid=1, searching from rr_ptr+1 upward, wrapping CHANNELS-1 -> 0.
REQ-020 rr_ptr SHALL update to the granted index only on round-robin grants; fixed-mode grants leave it unchanged.
REQ-021 in_ready SHALL be combinational: one-hot on the granted channel, all-zero when no grant.
REQ-022 On a grant, next cycle SHALL show out_valid=1, out_data = granted channel's data, out_chan = its index (1-cycle latency).
REQ-023 FULL with out_ready=0: out_data, out_chan, out_valid SHALL hold; in_ready all-zero.
REQ-024 FULL with out_ready=1 and a grant: SHALL reload in the same edge, sustaining one word per cycle.
REQ-025 FULL with out_ready=1 and no grant: SHALL go EMPTY; out_data/out_chan hold last values.
REQ-026 mode or sel changes SHALL affect only the next grant decision; a held word is never altered.
REQ-027 No in_valid asserted: SHALL make no grant; rr_ptr unchanged.

Reset
REQ-028 rst high SHALL immediately force out_valid=0, out_data=0, out_chan=0, rr_ptr=CHANNELS-1 (first RR search starts at channel 0).
REQ-029 rst asserted mid-transfer SHALL discard the held word; in_ready all-zero while rst is high.
REQ-030 First grant SHALL be possible on the first rising clk edge after rst deasserts.

Configuration
REQ-031 Macro CHAN_MUX_PARITY_EN defined: SHALL add output out_parity (1 bit), registered with out_data, equal to XOR of the granted word; reset value 0.
REQ-032 CHAN_MUX_PARITY_EN undefined: out_parity port and logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8, CHANNELS=4)
REQ-033 Reset: rst=1 mid-FULL -> out_valid=0, out_data=8'h00, out_chan=0 without a clk edge.
REQ-034 Fixed: mode=0, sel=2, in_valid=4'b1111, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100, next cycle out_data=8'hA5, out_chan=2.
REQ-035 Round-robin: mode=1, in_valid=4'b1011 held, out_ready=1 -> grant order 0,1,3,0,1,3 on consecutive cycles.
REQ-036 Backpressure: FULL with out_data=8'h3C, out_ready=0 for 5 cycles -> out_data holds 8'h3C, in_ready=4'b0000 throughout.
REQ-037 Boundary: mode=0, sel=2 with in_valid[2]=0, then only in_valid[3]=1 in mode=1 after rr_ptr=3 -> no grant, then wrap grants channel 3.
REQ-038 Parity (CHAN_MUX_PARITY_EN): granted word 8'b1011_0001 -> out_parity=0; 8'b1000_0000 -> out_parity=1.
